// File: rtl/data_mem_ctrl_pkg.sv
// Shared opcode/state types and opcode decode helpers for data_mem_ctrl.
package data_mem_ctrl_pkg;

  localparam int unsigned DataAddrBus = 32;
  localparam int unsigned DataBus     = 32;

  typedef enum logic [3:0] {
    OP_NOP = 4'b0000,
    OP_LB  = 4'b0001,
    OP_LBU = 4'b0010,
    OP_LH  = 4'b0011,
    OP_LHU = 4'b0100,
    OP_LW  = 4'b0101,
    OP_LL  = 4'b0110,
    OP_SB  = 4'b1001,
    OP_SH  = 4'b1010,
    OP_SW  = 4'b1011,
    OP_SC  = 4'b1100
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } state_e;

  function automatic logic is_load(input logic [3:0] op);
    return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LL};
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return op inside {OP_SB, OP_SH, OP_SW, OP_SC};
  endfunction

  function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] offset);
    case (op)
      OP_LH, OP_LHU, OP_SH:        return offset[0];
      OP_LW, OP_LL, OP_SW, OP_SC:  return offset != 2'b00;
      default:                     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_ctrl_lane_align.sv
// Combinational byte-lane steering: byte enables, store replication and
// load extraction/extension for a big-endian word RAM (lane 0 = bits 31:24).
module data_mem_ctrl_lane_align
  import data_mem_ctrl_pkg::*;
(
  input  logic [3:0]         op,
  input  logic [1:0]         offset,
  input  logic [DataBus-1:0] wdata,
  input  logic [DataBus-1:0] ram_rdata,
  output logic [3:0]         sel,
  output logic [DataBus-1:0] ram_wdata,
  output logic [DataBus-1:0] load_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (offset)
      2'd0:    byte_lane = ram_rdata[31:24];
      2'd1:    byte_lane = ram_rdata[23:16];
      2'd2:    byte_lane = ram_rdata[15:8];
      default: byte_lane = ram_rdata[7:0];
    endcase
    half_lane = offset[1] ? ram_rdata[15:0] : ram_rdata[31:16];
  end

  always_comb begin
    sel = '0;
    case (op)
      OP_LB, OP_LBU, OP_SB:       sel = 4'b1000 >> offset;
      OP_LH, OP_LHU, OP_SH:       sel = offset[1] ? 4'b0011 : 4'b1100;
      OP_LW, OP_LL, OP_SW, OP_SC: sel = 4'b1111;
      default:                    sel = '0;
    endcase
  end

  always_comb begin
    ram_wdata = '0;
    case (op)
      OP_SB:        ram_wdata = {4{wdata[7:0]}};
      OP_SH:        ram_wdata = {2{wdata[15:0]}};
      OP_SW, OP_SC: ram_wdata = wdata;
      default:      ram_wdata = '0;
    endcase
  end

  always_comb begin
    load_data = '0;
    case (op)
      OP_LB:        load_data = {{24{byte_lane[7]}}, byte_lane};
      OP_LBU:       load_data = {24'd0, byte_lane};
      OP_LH:        load_data = {{16{half_lane[15]}}, half_lane};
      OP_LHU:       load_data = {16'd0, half_lane};
      OP_LW, OP_LL: load_data = ram_rdata;
      default:      load_data = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store controller between the MEM stage and the byte-lane data RAM.
// Define DATA_MEM_CTRL_LLSC_EN to build the LL/SC link bit.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 0
)
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  input  logic [3:0]             req_op,
  input  logic [DataAddrBus-1:0] req_addr,
  input  logic [DataBus-1:0]     req_wdata,
  input  logic                   flush,
  output logic                   stall_req,
  output logic                   done,
  output logic [DataBus-1:0]     rdata,
  output logic                   excp_adel,
  output logic                   excp_ades,
  output logic                   ram_ce,
  output logic                   ram_we,
  output logic [DataAddrBus-1:0] ram_addr,
  output logic [3:0]             ram_sel,
  output logic [DataBus-1:0]     ram_wdata,
  input  logic [DataBus-1:0]     ram_rdata
);

  state_e           state;
  logic [3:0]       op_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       cnt;
  logic             access;
  logic             last_cycle;
  logic             sc_fail;
  logic [3:0]       lane_sel;
  logic [31:0]      lane_wdata;
  logic [31:0]      load_data;

  data_mem_ctrl_lane_align u_lane (
    .op        (op_q),
    .offset    (addr_q[1:0]),
    .wdata     (wdata_q),
    .ram_rdata (ram_rdata),
    .sel       (lane_sel),
    .ram_wdata (lane_wdata),
    .load_data (load_data)
  );

  assign access     = (state == ST_ACCESS);
  assign last_cycle = access && (cnt == 4'(WAIT_CYCLES));

  assign ram_ce    = access;
  assign ram_addr  = access ? {addr_q[31:2], 2'b00} : '0;
  assign ram_sel   = access ? lane_sel : '0;
  assign ram_wdata = access ? lane_wdata : '0;
  // Write strobe is combinational so flush/reset can veto the one write.
  assign ram_we    = last_cycle && is_store(op_q) && !flush && !rst;
  assign stall_req = !rst && (((state == ST_IDLE) && req_valid && !flush) || access);

`ifdef DATA_MEM_CTRL_LLSC_EN
  logic        link;
  logic [29:0] link_addr;

  assign sc_fail = (req_op == OP_SC) && !(link && (link_addr == req_addr[31:2]));

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      link <= 1'b0;
    end else if (last_cycle && (op_q == OP_LL)) begin
      link      <= 1'b1;
      link_addr <= addr_q[31:2];
    end else if (ram_we && (addr_q[31:2] == link_addr)) begin
      link <= 1'b0;
    end
  end
`else
  assign sc_fail = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      op_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt       <= '0;
      done      <= 1'b0;
      rdata     <= '0;
      excp_adel <= 1'b0;
      excp_ades <= 1'b0;
    end else begin
      done      <= 1'b0;
      rdata     <= '0;
      excp_adel <= 1'b0;
      excp_ades <= 1'b0;
      if (flush) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (req_valid) begin
              op_q    <= req_op;
              addr_q  <= req_addr;
              wdata_q <= req_wdata;
              if (is_misaligned(req_op, req_addr[1:0])) begin
                state     <= ST_DONE;
                done      <= 1'b1;
                excp_adel <= is_load(req_op);
                excp_ades <= is_store(req_op);
              end else if ((is_load(req_op) || is_store(req_op)) && !sc_fail) begin
                state <= ST_ACCESS;
              end else begin
                state <= ST_DONE;
                done  <= 1'b1;
              end
            end
          end
          ST_ACCESS: begin
            if (last_cycle) begin
              state <= ST_DONE;
              cnt   <= '0;
              done  <= 1'b1;
              if (is_load(op_q))
                rdata <= load_data;
              else if (op_q == OP_SC)
                rdata <= 32'd1;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomized self-checking bench for data_mem_ctrl against a byte-array memory model.
`timescale 1ns/1ps
module tb_data_mem_ctrl;
  import data_mem_ctrl_pkg::*;

  localparam int unsigned WAIT = 3;
  localparam int MAXC = 40;

  logic        clk = 1'b0;
  logic        rst, req_valid, flush;
  logic [3:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        stall_req, done, excp_adel, excp_ades, ram_ce, ram_we;
  logic [31:0] rdata, ram_addr, ram_wdata, ram_rdata;
  logic [3:0]  ram_sel;

  logic [31:0] ram [0:255];
  logic [7:0]  ref_bytes [0:1023];
  bit          ref_link;
  logic [29:0] ref_link_word;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_rdata;
  bit          exp_adel, exp_ades, exp_acc, exp_wr;

  int          obs_done_cyc, obs_writes, obs_ce_cycles;
  logic [31:0] obs_rdata, obs_wdata;
  logic [3:0]  obs_sel;
  logic        obs_adel, obs_ades;
  logic        stall_hist [0:MAXC-1];
  logic        we_hist    [0:MAXC-1];
  logic        ce_hist    [0:MAXC-1];

  data_mem_ctrl #(.WAIT_CYCLES(WAIT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .flush(flush), .stall_req(stall_req), .done(done), .rdata(rdata),
    .excp_adel(excp_adel), .excp_ades(excp_ades), .ram_ce(ram_ce), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_sel(ram_sel), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  assign ram_rdata = ram[ram_addr[9:2]];

  always @(posedge clk) begin
    if (ram_we) begin
      for (int j = 0; j < 4; j++)
        if (ram_sel[j]) ram[ram_addr[9:2]][8*j +: 8] <= ram_wdata[8*j +: 8];
    end
  end

  task automatic preload_word(input int idx, input logic [31:0] w);
    ram[idx] = w;
    for (int k = 0; k < 4; k++) ref_bytes[4*idx + k] = w[31-8*k -: 8];
  endtask

  // Reference: memory is a flat big-endian byte array; rules applied per opcode.
  task automatic ref_exec(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd);
    int size, a;
    bit ld, st, sgn;
    logic [31:0] v;
    exp_rdata = '0; exp_adel = 0; exp_ades = 0; exp_acc = 0; exp_wr = 0;
    size = 0; ld = 0; st = 0; sgn = 0;
    a = int'(addr[9:0]);
    case (op)
      OP_LB:        begin size = 1; ld = 1; sgn = 1; end
      OP_LBU:       begin size = 1; ld = 1; end
      OP_LH:        begin size = 2; ld = 1; sgn = 1; end
      OP_LHU:       begin size = 2; ld = 1; end
      OP_LW, OP_LL: begin size = 4; ld = 1; end
      OP_SB:        begin size = 1; st = 1; end
      OP_SH:        begin size = 2; st = 1; end
      OP_SW, OP_SC: begin size = 4; st = 1; end
      default:      size = 0;
    endcase
    if (size == 0) return;
    if ((a % size) != 0) begin
      exp_adel = ld; exp_ades = st;
      return;
    end
    if (ld) begin
      v = '0;
      for (int i = 0; i < size; i++) v = (v << 8) | {24'd0, ref_bytes[a+i]};
      if (sgn && v[8*size-1]) v = v | ~((32'd1 << (8*size)) - 32'd1);
      exp_rdata = v; exp_acc = 1;
`ifdef DATA_MEM_CTRL_LLSC_EN
      if (op == OP_LL) begin ref_link = 1; ref_link_word = addr[31:2]; end
`endif
    end else begin
`ifdef DATA_MEM_CTRL_LLSC_EN
      if (op == OP_SC && !(ref_link && ref_link_word == addr[31:2])) return;
      if (ref_link_word == addr[31:2]) ref_link = 0;
`endif
      for (int i = 0; i < size; i++) ref_bytes[a+i] = wd[8*(size-1-i) +: 8];
      exp_acc = 1; exp_wr = 1;
      exp_rdata = (op == OP_SC) ? 32'd1 : 32'd0;
    end
  endtask

  task automatic run_req(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input int abort_at = -1, input bit abort_rst = 0);
    obs_done_cyc = -1; obs_writes = 0; obs_ce_cycles = 0; obs_rdata = '0;
    obs_adel = 0; obs_ades = 0; obs_sel = '0; obs_wdata = '0;
    for (int i = 0; i < MAXC; i++) begin stall_hist[i] = 0; we_hist[i] = 0; ce_hist[i] = 0; end
    @(negedge clk);
    req_valid = 1; req_op = op; req_addr = addr; req_wdata = wd;
    #1;
    stall_hist[0] = stall_req; we_hist[0] = ram_we; ce_hist[0] = ram_ce;
    for (int c = 1; c < MAXC; c++) begin
      @(negedge clk);
      req_valid = 0;
      if (c == abort_at) begin
        if (abort_rst) rst = 1; else flush = 1;
      end else if (c == abort_at + 1) begin
        rst = 0; flush = 0;
      end
      #1;
      stall_hist[c] = stall_req; we_hist[c] = ram_we; ce_hist[c] = ram_ce;
      if (ram_ce) begin obs_ce_cycles++; obs_sel = ram_sel; end
      if (ram_we) begin obs_writes++; obs_wdata = ram_wdata; end
      if (done) begin
        obs_done_cyc = c; obs_rdata = rdata; obs_adel = excp_adel; obs_ades = excp_ades;
        break;
      end
      if (abort_at > 0 && c == abort_at + 2) break;
    end
    if (abort_at < 0) begin
      checks++;
      if (obs_done_cyc < 0) begin
        errors++; $display("FAIL timeout: no done within %0d cycles, required done", MAXC);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1; req_valid = 1; req_op = OP_LW; req_addr = 32'h10; req_wdata = 32'hFFFF_FFFF; flush = 0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({stall_req, done, excp_adel, excp_ades, ram_ce, ram_we, ram_sel} !== 10'd0) begin
      errors++; $display("FAIL reset_ctrl: got %b required 0", {stall_req, done, excp_adel, excp_ades, ram_ce, ram_we, ram_sel});
    end
    checks++;
    if ({rdata, ram_addr, ram_wdata} !== 96'd0) begin
      errors++; $display("FAIL reset_data: got %h %h %h required 0", rdata, ram_addr, ram_wdata);
    end
    @(negedge clk);
    rst = 0; req_valid = 0;
  endtask

  task automatic test_lw();
    preload_word(4, 32'h8899AABB);
    ref_exec(OP_LW, 32'h10, '0);
    run_req(OP_LW, 32'h10, '0);
    checks++; if (obs_sel !== 4'b1111) begin errors++; $display("FAIL lw_sel: got %b required 1111", obs_sel); end
    checks++; if (obs_done_cyc !== 2 + WAIT) begin errors++; $display("FAIL lw_done_cycle: got %0d required %0d", obs_done_cyc, 2 + WAIT); end
    checks++; if (obs_rdata !== 32'h8899AABB) begin errors++; $display("FAIL lw_rdata: got %h required 8899aabb", obs_rdata); end
  endtask

  task automatic test_byte();
    ref_exec(OP_SB, 32'h21, 32'h000000A5);
    run_req(OP_SB, 32'h21, 32'h000000A5);
    checks++; if (obs_sel !== 4'b0100) begin errors++; $display("FAIL sb_sel: got %b required 0100", obs_sel); end
    checks++; if (obs_wdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL sb_wdata: got %h required a5a5a5a5", obs_wdata); end
    checks++; if (obs_writes !== 1) begin errors++; $display("FAIL sb_writes: got %0d required 1", obs_writes); end
    ref_exec(OP_LB, 32'h21, '0);
    run_req(OP_LB, 32'h21, '0);
    checks++; if (obs_rdata !== 32'hFFFFFFA5) begin errors++; $display("FAIL lb_rdata: got %h required ffffffa5", obs_rdata); end
    ref_exec(OP_LBU, 32'h21, '0);
    run_req(OP_LBU, 32'h21, '0);
    checks++; if (obs_rdata !== 32'h000000A5) begin errors++; $display("FAIL lbu_rdata: got %h required 000000a5", obs_rdata); end
  endtask

  task automatic test_half();
    ref_exec(OP_SH, 32'h32, 32'h0000BEEF);
    run_req(OP_SH, 32'h32, 32'h0000BEEF);
    checks++; if (obs_sel !== 4'b0011) begin errors++; $display("FAIL sh_sel: got %b required 0011", obs_sel); end
    checks++; if (obs_wdata !== 32'hBEEFBEEF) begin errors++; $display("FAIL sh_wdata: got %h required beefbeef", obs_wdata); end
    ref_exec(OP_LH, 32'h32, '0);
    run_req(OP_LH, 32'h32, '0);
    checks++; if (obs_rdata !== 32'hFFFFBEEF) begin errors++; $display("FAIL lh_rdata: got %h required ffffbeef", obs_rdata); end
    ref_exec(OP_LHU, 32'h32, '0);
    run_req(OP_LHU, 32'h32, '0);
    checks++; if (obs_rdata !== 32'h0000BEEF) begin errors++; $display("FAIL lhu_rdata: got %h required 0000beef", obs_rdata); end
  endtask

  task automatic test_misaligned();
    ref_exec(OP_LH, 32'h13, '0);
    run_req(OP_LH, 32'h13, '0);
    checks++; if (obs_done_cyc !== 1) begin errors++; $display("FAIL adel_done_cycle: got %0d required 1", obs_done_cyc); end
    checks++; if ({obs_adel, obs_ades} !== 2'b10) begin errors++; $display("FAIL adel_flags: got %b required 10", {obs_adel, obs_ades}); end
    checks++; if (obs_ce_cycles !== 0) begin errors++; $display("FAIL adel_ce: got %0d required 0", obs_ce_cycles); end
    ref_exec(OP_SW, 32'h22, 32'h01020304);
    run_req(OP_SW, 32'h22, 32'h01020304);
    checks++; if ({obs_adel, obs_ades} !== 2'b01) begin errors++; $display("FAIL ades_flags: got %b required 01", {obs_adel, obs_ades}); end
    checks++; if (obs_writes !== 0) begin errors++; $display("FAIL ades_writes: got %0d required 0", obs_writes); end
  endtask

  task automatic test_stall_timing();
    ref_exec(OP_SW, 32'h40, 32'hDEADBEEF);
    run_req(OP_SW, 32'h40, 32'hDEADBEEF);
    for (int c = 0; c <= 2 + int'(WAIT); c++) begin
      checks++;
      if (stall_hist[c] !== (c <= 1 + int'(WAIT))) begin
        errors++; $display("FAIL stall_c%0d: got %b required %b", c, stall_hist[c], c <= 1 + int'(WAIT));
      end
      checks++;
      if (we_hist[c] !== (c == 1 + int'(WAIT))) begin
        errors++; $display("FAIL we_c%0d: got %b required %b", c, we_hist[c], c == 1 + int'(WAIT));
      end
    end
    checks++; if (obs_done_cyc !== 2 + WAIT) begin errors++; $display("FAIL sw_done_cycle: got %0d required %0d", obs_done_cyc, 2 + WAIT); end
  endtask

  task automatic test_flush();
    run_req(OP_SW, 32'h40, 32'h11111111, 1 + WAIT, 0);
    ref_link = 0;
    checks++; if (we_hist[1+WAIT] !== 1'b0) begin errors++; $display("FAIL flush_we: got %b required 0", we_hist[1+WAIT]); end
    checks++; if (obs_done_cyc !== -1) begin errors++; $display("FAIL flush_done: got %0d required -1 (none)", obs_done_cyc); end
    checks++; if ({stall_hist[2+WAIT], ce_hist[2+WAIT]} !== 2'b00) begin
      errors++; $display("FAIL flush_idle: got %b required 00", {stall_hist[2+WAIT], ce_hist[2+WAIT]});
    end
    ref_exec(OP_LW, 32'h40, '0);
    run_req(OP_LW, 32'h40, '0);
    checks++; if (obs_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL flush_mem: got %h required deadbeef", obs_rdata); end
  endtask

  task automatic test_reset_mid();
    ref_exec(OP_LW, 32'h44, '0);
    run_req(OP_SW, 32'h44, 32'hCAFEF00D, 1 + WAIT, 1);
    ref_link = 0;
    checks++; if (we_hist[1+WAIT] !== 1'b0) begin errors++; $display("FAIL rstmid_we: got %b required 0", we_hist[1+WAIT]); end
    checks++; if (ce_hist[2+WAIT] !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got %b required 0", ce_hist[2+WAIT]); end
    run_req(OP_LW, 32'h44, '0);
    checks++; if (obs_rdata !== exp_rdata) begin errors++; $display("FAIL rstmid_mem: got %h required %h", obs_rdata, exp_rdata); end
  endtask

  task automatic test_llsc();
    ref_exec(OP_LL, 32'h80, '0);
    run_req(OP_LL, 32'h80, '0);
    checks++; if (obs_rdata !== exp_rdata) begin errors++; $display("FAIL ll_rdata: got %h required %h", obs_rdata, exp_rdata); end
    ref_exec(OP_SC, 32'h80, 32'h12345678);
    run_req(OP_SC, 32'h80, 32'h12345678);
    checks++; if ({obs_rdata, obs_writes} !== {32'd1, 32'd1}) begin errors++; $display("FAIL sc1: got rdata %h writes %0d required 1/1", obs_rdata, obs_writes); end
    ref_exec(OP_SC, 32'h80, 32'hAAAA5555);
    run_req(OP_SC, 32'h80, 32'hAAAA5555);
`ifdef DATA_MEM_CTRL_LLSC_EN
    checks++; if ({obs_rdata, obs_writes, obs_done_cyc} !== {32'd0, 32'd0, 32'd1}) begin
      errors++; $display("FAIL sc2: got rdata %h writes %0d done %0d required 0/0/1", obs_rdata, obs_writes, obs_done_cyc);
    end
    ref_exec(OP_LL, 32'h80, '0);
    run_req(OP_LL, 32'h80, '0);
    @(negedge clk); flush = 1;
    @(negedge clk); flush = 0;
    ref_link = 0;
    ref_exec(OP_SC, 32'h80, 32'h0BADF00D);
    run_req(OP_SC, 32'h80, 32'h0BADF00D);
    checks++; if ({obs_rdata, obs_writes} !== {32'd0, 32'd0}) begin errors++; $display("FAIL sc_flushed: got rdata %h writes %0d required 0/0", obs_rdata, obs_writes); end
`else
    checks++; if ({obs_rdata, obs_writes, obs_done_cyc} !== {32'd1, 32'd1, 32'(2 + WAIT)}) begin
      errors++; $display("FAIL sc2: got rdata %h writes %0d done %0d required 1/1/%0d", obs_rdata, obs_writes, obs_done_cyc, 2 + WAIT);
    end
`endif
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] addr, wd;
    for (int n = 0; n < 80; n++) begin
      op   = 4'($urandom_range(0, 15));
      addr = 32'h100 + 32'($urandom_range(0, 31));
      wd   = $urandom;
      ref_exec(op, addr, wd);
      run_req(op, addr, wd);
      checks++; if (obs_rdata !== exp_rdata) begin errors++; $display("FAIL rnd%0d_rdata op %h addr %h: got %h required %h", n, op, addr, obs_rdata, exp_rdata); end
      checks++; if ({obs_adel, obs_ades} !== {exp_adel, exp_ades}) begin errors++; $display("FAIL rnd%0d_excp: got %b required %b", n, {obs_adel, obs_ades}, {exp_adel, exp_ades}); end
      checks++; if (obs_done_cyc !== (exp_acc ? 2 + int'(WAIT) : 1)) begin errors++; $display("FAIL rnd%0d_done_cycle: got %0d required %0d", n, obs_done_cyc, exp_acc ? 2 + int'(WAIT) : 1); end
      checks++; if (obs_writes !== int'(exp_wr)) begin errors++; $display("FAIL rnd%0d_writes: got %0d required %0d", n, obs_writes, exp_wr); end
    end
  endtask

  initial begin
    rst = 1; req_valid = 0; flush = 0; req_op = '0; req_addr = '0; req_wdata = '0;
    ref_link = 0; ref_link_word = '0;
    for (int i = 0; i < 256; i++) preload_word(i, $urandom);
    test_reset();
    test_lw();
    test_byte();
    test_half();
    test_misaligned();
    test_stall_timing();
    test_flush();
    test_reset_mid();
    test_llsc();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
